// File: rtl/l2_cache_control.sv
// l2_cache_control
//   Sequencing FSM for the 2-way L2 cache datapath. It decodes hit/miss from
//   the datapath tag compare, drives every array strobe and mux select of the
//   datapath, runs dirty-victim writeback and line fill over the pmem
//   handshake, and keeps saturating hit/miss counters.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   mem_read, mem_write           upstream request (held until mem_resp)
//   mem_resp                      one-cycle completion pulse
//   pmem_read, pmem_write         line fill / line writeback request
//   pmem_resp                     physical memory done (one cycle)
//   tag_0_hit, tag_1_hit          datapath per-way tag match
//   replace                       datapath victim way
//   dirt_0, dirt_1                datapath per-way valid-and-dirty
//   load_tag_*, load_valid_*,
//   load_dirty_*, load_lru        datapath array write strobes
//   dirty_in_0, dirty_in_1        dirty bit value to write
//   update                        00 idle, 10 fill way0, 01 fill way1, 11 CPU write
//   write_way                     way written by a CPU write hit
//   data_select                   0 = CPU wdata, 1 = pmem_rdata
//   pmem_out_sel                  0 = request address, 1 = victim address
//   hit_count, miss_count         saturating performance counters
module l2_cache_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic             tag_0_hit,
  input  logic             tag_1_hit,
  input  logic             replace,
  input  logic             dirt_0,
  input  logic             dirt_1,
  output logic             load_tag_0,
  output logic             load_tag_1,
  output logic             load_valid_0,
  output logic             load_valid_1,
  output logic             load_dirty_0,
  output logic             load_dirty_1,
  output logic             load_lru,
  output logic             dirty_in_0,
  output logic             dirty_in_1,
  output logic [1:0]       update,
  output logic             write_way,
  output logic             data_select,
  output logic             pmem_out_sel,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_t;

  state_t state, state_nxt;

  // fill_settle: first CHECK cycle after a fill; the arrays were written on
  // the fill edge and the tag compare is not valid until the next cycle.
  // post_fill: the coming CHECK completion is the re-compare of a miss and
  // must not be counted as a hit.
  logic fill_settle, fill_settle_nxt;
  logic post_fill, post_fill_nxt;
  logic hit_inc, miss_inc;
  logic hit, req, victim_dirty;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign hit          = tag_0_hit | tag_1_hit;
  assign req          = mem_read | mem_write;
  assign victim_dirty = replace ? dirt_1 : dirt_0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fill_settle <= 1'b0;
      post_fill   <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      state       <= state_nxt;
      fill_settle <= fill_settle_nxt;
      post_fill   <= post_fill_nxt;
      if (hit_inc)  hit_count  <= sat_inc(hit_count);
      if (miss_inc) miss_count <= sat_inc(miss_count);
    end
  end

  always_comb begin
    state_nxt       = state;
    fill_settle_nxt = fill_settle;
    post_fill_nxt   = post_fill;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    load_tag_0      = 1'b0;
    load_tag_1      = 1'b0;
    load_valid_0    = 1'b0;
    load_valid_1    = 1'b0;
    load_dirty_0    = 1'b0;
    load_dirty_1    = 1'b0;
    load_lru        = 1'b0;
    dirty_in_0      = 1'b0;
    dirty_in_1      = 1'b0;
    update          = 2'b00;
    write_way       = 1'b0;
    data_select     = 1'b0;
    pmem_out_sel    = 1'b0;

    unique case (state)
      IDLE: begin
        fill_settle_nxt = 1'b0;
        post_fill_nxt   = 1'b0;
        if (req) state_nxt = CHECK;
      end

      CHECK: begin
        if (fill_settle) begin
          fill_settle_nxt = 1'b0;
        end else if (!req) begin
          state_nxt     = IDLE;
          post_fill_nxt = 1'b0;
        end else if (hit) begin
          mem_resp      = 1'b1;
          load_lru      = 1'b1;
          hit_inc       = !post_fill;
          post_fill_nxt = 1'b0;
          state_nxt     = IDLE;
          // mem_write wins when both requests are high
          if (mem_write) begin
            update    = 2'b11;
            write_way = tag_1_hit;
            if (tag_1_hit) begin
              load_dirty_1 = 1'b1;
              dirty_in_1   = 1'b1;
            end else begin
              load_dirty_0 = 1'b1;
              dirty_in_0   = 1'b1;
            end
          end
        end else begin
          miss_inc      = 1'b1;
          post_fill_nxt = 1'b0;
          state_nxt     = victim_dirty ? WRITEBACK : FILL;
        end
      end

      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_out_sel = 1'b1;
        if (pmem_resp) state_nxt = FILL;
      end

      FILL: begin
        pmem_read   = 1'b1;
        data_select = 1'b1;
        if (pmem_resp) begin
          state_nxt       = CHECK;
          fill_settle_nxt = 1'b1;
          post_fill_nxt   = 1'b1;
          // a reset landing on the response cycle must not write the arrays
          if (!rst) begin
            update       = replace ? 2'b01 : 2'b10;
            load_tag_0   = ~replace;
            load_tag_1   = replace;
            load_valid_0 = ~replace;
            load_valid_1 = replace;
            load_dirty_0 = ~replace;
            load_dirty_1 = replace;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
